// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: walks one external 1-bit slice across WIDTH bits,
// with a second pass for SLT so the final sign test sees the full subtraction.
module alu_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             s_a,
   output logic             s_b,
   output logic             s_set,
   output logic             s_inva,
   output logic             s_invb,
   output logic             s_ci,
   output logic [1:0]       s_sel,
   input  logic             s_f,
   input  logic             s_sgn,
   input  logic             s_co
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      PASS1,
      PASS2,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       op_q;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             less;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] res_n;
   logic             last;
   logic             drive;

   assign last  = (idx == IW'(WIDTH - 1));
   assign drive = (state == PASS1) || (state == PASS2);
   assign busy  = drive;
   assign done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = (op[1:0] == 2'b11) ? PASS1 : PASS2;
            end
         end
         PASS1: begin
            if (last) begin
               state_n = PASS2;
            end
         end
         PASS2: begin
            if (last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Slice drive comes only from registered state, never from start.
   always_comb begin
      s_a    = 1'b0;
      s_b    = 1'b0;
      s_inva = 1'b0;
      s_invb = 1'b0;
      s_ci   = 1'b0;
      s_set  = 1'b0;
      s_sel  = 2'b00;
      if (drive) begin
         s_a    = a_q[idx];
         s_b    = b_q[idx];
         s_inva = op_q[3];
         s_invb = op_q[2];
         s_ci   = carry;
      end
      unique case (1'b1)
         (state == PASS1): begin
            s_sel = 2'b10;
         end
         (state == PASS2): begin
            s_sel = op_q[1:0];
            s_set = (idx == '0) ? less : 1'b0;
         end
         default: begin
            s_sel = 2'b00;
         end
      endcase
   end

   always_comb begin
      res_n      = acc;
      res_n[idx] = s_f;
   end

   // Bits accumulate in acc; result/flags move together on the final edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         less   <= 1'b0;
         acc    <= '0;
         result <= '0;
         zero   <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  op_q  <= op;
                  idx   <= '0;
                  carry <= op[2];
               end
            end
            PASS1: begin
               carry <= s_co;
               idx   <= idx + IW'(1);
               if (last) begin
                  less  <= s_sgn ^ (s_ci ^ s_co);
                  idx   <= '0;
                  carry <= op_q[2];
               end
            end
            PASS2: begin
               acc[idx] <= s_f;
               carry    <= s_co;
               idx      <= idx + IW'(1);
               if (last) begin
                  result <= res_n;
                  zero   <= (res_n == '0);
                  ovf    <= (op_q[1:0] == 2'b10) & (s_ci ^ s_co);
                  idx    <= '0;
               end
            end
            DONE: begin
               idx <= '0;
            end
            default: begin
               idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit slice attached.
module tb_alu_serial_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;
   logic         ovf;
   logic         s_a;
   logic         s_b;
   logic         s_set;
   logic         s_inva;
   logic         s_invb;
   logic         s_ci;
   logic [1:0]   s_sel;
   logic         s_f;
   logic         s_sgn;
   logic         s_co;

   int n_tests;
   int n_fail;
   int done_cnt;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .zero(zero), .ovf(ovf),
      .s_a(s_a), .s_b(s_b), .s_set(s_set), .s_inva(s_inva),
      .s_invb(s_invb), .s_ci(s_ci), .s_sel(s_sel),
      .s_f(s_f), .s_sgn(s_sgn), .s_co(s_co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference 1-bit ALU slice.
   logic ai;
   logic bi;
   logic sum;
   always_comb begin
      ai    = s_a ^ s_inva;
      bi    = s_b ^ s_invb;
      sum   = ai ^ bi ^ s_ci;
      s_co  = (ai & bi) | (ai & s_ci) | (bi & s_ci);
      s_sgn = sum;
      case (s_sel)
         2'b00:   s_f = ai & bi;
         2'b01:   s_f = ai | bi;
         2'b10:   s_f = sum;
         default: s_f = s_set;
      endcase
   end

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // poke=1 holds start high with another op through busy and DONE.
   task automatic run_op(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit poke,
                         output int lat);
      @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      lat   = 1;
      start = poke;
      op    = 4'b0000;
      a     = ~x;
      b     = ~y;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!done) chk("timeout", 32'(lat), 32'd0);
      if (poke) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         chk("start_in_done_ignored", 32'(busy), 32'd0);
      end
   endtask

   task automatic check_op(input string tag, input logic [3:0] o,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] er, input logic ez,
                           input logic ev, input int el);
      int lat;
      run_op(o, x, y, 1'b0, lat);
      chk({tag, "_res"}, 32'(result), 32'(er));
      chk({tag, "_zero"}, 32'(zero), 32'(ez));
      chk({tag, "_ovf"}, 32'(ovf), 32'(ev));
      chk({tag, "_lat"}, 32'(lat), 32'(el));
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_res_hold"}, 32'(result), 32'(er));
   endtask

   initial begin
      int lat;
      int dc;
      n_tests  = 0;
      n_fail   = 0;
      done_cnt = 0;
      rst      = 1'b1;
      start    = 1'b0;
      op       = 4'b0000;
      a        = '0;
      b        = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_slice", 32'({s_a, s_b, s_set, s_inva, s_invb, s_ci, s_sel}),
          32'd0);
      rst = 1'b0;

      check_op("add_ovf", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 9);
      check_op("sub_zero", 4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 9);
      check_op("sub_ovf", 4'b0110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 9);
      check_op("slt_neg", 4'b0111, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 17);
      check_op("slt_ovf", 4'b0111, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 17);
      check_op("slt_eq", 4'b0111, 8'h02, 8'h02, 8'h00, 1'b1, 1'b0, 17);
      check_op("and", 4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 9);
      check_op("or", 4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 9);
      check_op("nor", 4'b1100, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, 9);

      dc = done_cnt;
      run_op(4'b0010, 8'h11, 8'h22, 1'b1, lat);
      chk("poke_res", 32'(result), 32'h33);
      chk("poke_lat", 32'(lat), 32'd9);
      chk("poke_done_cnt", 32'(done_cnt - dc), 32'd1);

      dc = done_cnt;
      @(negedge clk);
      op    = 4'b0010;
      a     = 8'h7F;
      b     = 8'h7F;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_zero", 32'(zero), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt - dc), 32'd0);

      check_op("add_after", 4'b0010, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
